cv32e40p_fetch_queue: RTL and testbench

Instruction-fetch front end that sits directly upstream of the IF-stage aligner. It issues word-aligned OBI instruction requests and tracks outstanding transactions. Returned words are buffered in a small FIFO and presented to the IF stage on a valid/ready interface. On a branch or hardware-loop jump it flushes buffered words, discards in-flight responses, and restarts fetching at the new target.

---
 rtl/cv32e40p_pkg.sv | 11 +
 rtl/cv32e40p_fetch_fifo.sv | 67 ++++++
 rtl/cv32e40p_fetch_queue.sv | 118 +++++++++++
 tb/tb_cv32e40p_fetch_queue.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_pkg.sv
// Shared fetch-path helpers used by the fetch queue and its FIFO.
package cv32e40p_pkg;

    localparam logic [31:0] FETCH_WORD_BYTES = 32'd4;

    // The aligner resolves halfword offsets, so fetches always use the containing word.
    function automatic logic [31:0] alignWord(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/cv32e40p_fetch_fifo.sv
// DEPTH x 32 word FIFO with synchronous clear and a first-word bypass when empty.
module cv32e40p_fetch_fifo
    import cv32e40p_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             in_valid_i,
    input  logic [31:0]      in_data_i,
    input  logic             out_ready_i,
    output logic             out_valid_o,
    output logic [31:0]      out_data_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W-1:0] r_wrPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_empty;
    logic             w_full;
    logic             w_bypass;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_bypass    = w_empty & in_valid_i;
    // A bypassed word that is consumed immediately never occupies an entry.
    assign w_push      = in_valid_i & ~(w_bypass & out_ready_i);
    assign w_pop       = ~w_empty & out_ready_i;
    assign out_valid_o = ~w_empty | in_valid_i;
    assign out_data_o  = ~w_empty ? r_mem[r_rdPtr] : (in_valid_i ? in_data_i : '0);
    assign count_o     = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else if (clear_i) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= ptrInc(r_wrPtr);
            if (w_pop)  r_rdPtr <= ptrInc(r_rdPtr);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push & ~clear_i) r_mem[r_wrPtr] <= in_data_i;
    end

    pushNotFull: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && w_full && !w_pop && !clear_i));

endmodule

// File: rtl/cv32e40p_fetch_queue.sv
// Fetch front end: issues word-aligned OBI fetches, tracks outstanding transactions,
// buffers returned words and discards responses made stale by branch/hwloop redirects.
module cv32e40p_fetch_queue
    import cv32e40p_pkg::*;
#(
    parameter int DEPTH           = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        hwlp_jump_i,
    input  logic [31:0] hwlp_target_i,
    input  logic        fetch_ready_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_rdata_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        busy_o
);
    localparam int               CNT_W     = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]   DEPTH_LIM = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] OUTS_LIM  = CNT_W'(MAX_OUTSTANDING);

    logic             r_active;
    logic             r_reqHold;
    logic             r_pendRedirect;
    logic [31:0]      r_pendTarget;
    logic [31:0]      r_addr;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_flushCnt;

    logic             w_redirect;
    logic [31:0]      w_target;
    logic [CNT_W-1:0] w_fifoCnt;
    logic [CNT_W:0]   w_credit;
    logic             w_canIssue;
    logic             w_gnt;
    logic             w_rsp;
    logic             w_flushing;
    logic             w_drop;
    logic             w_deliver;
    logic [CNT_W-1:0] w_outstandingNext;
    logic             w_unusedErr;

    assign w_redirect  = branch_i | hwlp_jump_i;
    assign w_target    = alignWord(branch_i ? branch_addr_i : hwlp_target_i);
    assign w_credit    = {1'b0, r_outstanding} + {1'b0, w_fifoCnt};
    assign w_canIssue  = r_active & req_i & (w_credit < DEPTH_LIM) & (r_outstanding < OUTS_LIM);
    // A request left ungranted must stay asserted with a stable address (OBI).
    assign instr_req_o  = r_reqHold | w_canIssue;
    assign instr_addr_o = r_addr;
    assign w_gnt        = instr_req_o & instr_gnt_i;
    assign w_rsp        = instr_rvalid_i & (r_outstanding != '0);
    assign w_flushing   = (r_flushCnt != '0);
    assign w_drop       = w_redirect | w_flushing;
    assign w_deliver    = w_rsp & ~w_drop;
    assign busy_o       = instr_req_o | (r_outstanding != '0);
    assign w_outstandingNext = r_outstanding + CNT_W'(w_gnt) - CNT_W'(w_rsp);
    assign w_unusedErr  = instr_err_i;

    // On a redirect every transaction still in flight after this cycle is stale;
    // a held request granted later is stale too and is added to the flush count then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active       <= 1'b0;
            r_reqHold      <= 1'b0;
            r_pendRedirect <= 1'b0;
            r_pendTarget   <= '0;
            r_addr         <= '0;
            r_outstanding  <= '0;
            r_flushCnt     <= '0;
        end else begin
            r_outstanding <= w_outstandingNext;
            r_reqHold     <= instr_req_o & ~instr_gnt_i;
            if (w_redirect) begin
                r_active   <= 1'b1;
                r_flushCnt <= w_outstandingNext;
                if (instr_req_o & ~instr_gnt_i) begin
                    r_pendRedirect <= 1'b1;
                    r_pendTarget   <= w_target;
                end else begin
                    r_pendRedirect <= 1'b0;
                    r_addr         <= w_target;
                end
            end else begin
                r_flushCnt <= r_flushCnt - CNT_W'(w_rsp & w_flushing)
                                         + CNT_W'(w_gnt & r_pendRedirect);
                if (w_gnt) begin
                    r_addr         <= r_pendRedirect ? r_pendTarget : r_addr + FETCH_WORD_BYTES;
                    r_pendRedirect <= 1'b0;
                end
            end
        end
    end

    cv32e40p_fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (w_redirect),
        .in_valid_i  (w_deliver),
        .in_data_i   (instr_rdata_i),
        .out_ready_i (fetch_ready_i),
        .out_valid_o (fetch_valid_o),
        .out_data_o  (fetch_rdata_o),
        .count_o     (w_fifoCnt)
    );

endmodule

// File: tb/tb_cv32e40p_fetch_queue.sv
// Self-checking bench for cv32e40p_fetch_queue: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_cv32e40p_fetch_queue;
    localparam int DEPTH = 2;
    localparam int MAXO  = 2;
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_i, branch_i, hwlp_jump_i, fetch_ready_i;
    logic        instr_gnt_i, instr_rvalid_i, instr_err_i;
    logic [31:0] branch_addr_i, hwlp_target_i, instr_rdata_i;
    logic        fetch_valid_o, instr_req_o, busy_o;
    logic [31:0] fetch_rdata_o, instr_addr_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cv32e40p_fetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_i          (req_i),
        .branch_i       (branch_i),
        .branch_addr_i  (branch_addr_i),
        .hwlp_jump_i    (hwlp_jump_i),
        .hwlp_target_i  (hwlp_target_i),
        .fetch_ready_i  (fetch_ready_i),
        .fetch_valid_o  (fetch_valid_o),
        .fetch_rdata_o  (fetch_rdata_o),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_err_i    (instr_err_i),
        .busy_o         (busy_o)
    );

    // Reference model: in-flight bus transactions tagged stale on redirect, FIFO as a queue.
    typedef struct { logic [31:0] addr; bit stale; } txn_t;
    txn_t        busQ[$];
    logic [31:0] fifoQ[$];
    bit          mActive, mHeld, mPend, mDrop, mBypass;
    logic [31:0] mAddr, mPendTgt;
    bit          eReq, eValid, eBusy;
    logic [31:0] eData;

    typedef struct {
        bit req; bit br; logic [31:0] baddr; bit rdy; bit gnt; bit rv;
        bit eReq; logic [31:0] eAddr; bit eValid; logic [31:0] eDataAddr; bit eBusy;
    } vec_t;
    vec_t vecs[15];

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        busQ.delete();
        fifoQ.delete();
        mActive = 0; mHeld = 0; mPend = 0;
        mAddr = '0; mPendTgt = '0;
    endtask

    task automatic checkReset(input string tag);
        check({tag, "Req"},   instr_req_o,   32'h0);
        check({tag, "Addr"},  instr_addr_o,  32'h0);
        check({tag, "Valid"}, fetch_valid_o, 32'h0);
        check({tag, "Rdata"}, fetch_rdata_o, 32'h0);
        check({tag, "Busy"},  busy_o,        32'h0);
    endtask

    task automatic checkOutput();
        bit redirect;
        redirect = branch_i | hwlp_jump_i;
        eReq    = mHeld | (mActive && req_i && (busQ.size() + fifoQ.size() < DEPTH)
                                  && (busQ.size() < MAXO));
        mDrop   = instr_rvalid_i && (busQ[0].stale || redirect);
        mBypass = instr_rvalid_i && !mDrop && (fifoQ.size() == 0);
        eValid  = (fifoQ.size() > 0) || mBypass;
        eData   = (fifoQ.size() > 0) ? fifoQ[0] : (mBypass ? memWord(busQ[0].addr) : 32'h0);
        eBusy   = eReq || (busQ.size() != 0);
        check("req", instr_req_o, eReq);
        if (eReq) check("addr", instr_addr_o, mAddr);
        check("valid", fetch_valid_o, eValid);
        if (eValid) check("rdata", fetch_rdata_o, eData);
        check("busy", busy_o, eBusy);
    endtask

    task automatic updateModel();
        bit          g, redirect, hs;
        logic [31:0] tgt, word;
        g        = eReq && instr_gnt_i;
        redirect = branch_i | hwlp_jump_i;
        tgt      = (branch_i ? branch_addr_i : hwlp_target_i) & 32'hFFFF_FFFC;
        hs       = eValid && fetch_ready_i;
        word     = '0;
        if (instr_rvalid_i) begin
            word = memWord(busQ[0].addr);
            void'(busQ.pop_front());
        end
        if (redirect) fifoQ.delete();
        else begin
            if (hs && fifoQ.size() > 0) void'(fifoQ.pop_front());
            if (instr_rvalid_i && !mDrop && !(mBypass && fetch_ready_i)) fifoQ.push_back(word);
        end
        if (g) busQ.push_back('{addr: mAddr, stale: mPend});
        if (redirect) foreach (busQ[i]) busQ[i].stale = 1;
        if (redirect) begin
            mActive = 1;
            if (eReq && !instr_gnt_i) begin mPend = 1; mPendTgt = tgt; end
            else begin mAddr = tgt; mPend = 0; end
        end else if (g) begin
            mAddr = mPend ? mPendTgt : mAddr + 32'd4;
            mPend = 0;
        end
        mHeld = eReq && !instr_gnt_i;
    endtask

    // One cycle: drive at the falling edge, check 1 time unit later, advance the model.
    task automatic applyStimulus(input bit req, input bit br, input logic [31:0] baddr,
                                 input bit hw, input logic [31:0] htgt,
                                 input bit rdy, input bit gnt, input bit rv);
        @(negedge clk);
        req_i          = req;
        branch_i       = br;
        branch_addr_i  = baddr;
        hwlp_jump_i    = hw;
        hwlp_target_i  = htgt;
        fetch_ready_i  = rdy;
        instr_gnt_i    = gnt;
        instr_rvalid_i = rv && (busQ.size() > 0);
        instr_rdata_i  = instr_rvalid_i ? memWord(busQ[0].addr) : $urandom;
        instr_err_i    = instr_rvalid_i ? 1'($urandom_range(0, 1)) : 1'b0;
        #1;
        checkOutput();
        updateModel();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (busQ.size() > 0 || fifoQ.size() > 0 || mHeld); i++)
            applyStimulus(L, L, 0, L, 0, H, H, H);
        if (busQ.size() > 0 || fifoQ.size() > 0 || mHeld) begin
            checks++; errors++;
            $display("[TB] FAIL drain: got pending=%0d expected 0", busQ.size() + fifoQ.size());
        end
    endtask

    task automatic expectFirstWord(input logic [31:0] a, input string name);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            applyStimulus(H, L, 0, L, 0, H, H, H);
            if (fetch_valid_o) begin
                seen = 1;
                check(name, fetch_rdata_o, memWord(a));
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("[TB] FAIL %s: got no word in 20 cycles expected %h", name, memWord(a));
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // req, br, baddr, rdy, gnt, rv | eReq, eAddr, eValid, eDataAddr, eBusy
        vecs[0]  = '{H, H, 32'h82, H, H, L,  L, 32'h00, L, 32'h00, L};
        vecs[1]  = '{H, L, 32'h00, H, H, L,  H, 32'h80, L, 32'h00, H};
        vecs[2]  = '{H, L, 32'h00, H, H, H,  H, 32'h84, H, 32'h80, H};
        vecs[3]  = '{H, L, 32'h00, H, H, H,  H, 32'h88, H, 32'h84, H};
        vecs[4]  = '{H, L, 32'h00, H, L, H,  H, 32'h8C, H, 32'h88, H};
        vecs[5]  = '{H, L, 32'h00, L, H, L,  H, 32'h8C, L, 32'h00, H};
        vecs[6]  = '{H, L, 32'h00, L, H, L,  H, 32'h90, L, 32'h00, H};
        vecs[7]  = '{H, L, 32'h00, L, H, H,  L, 32'h00, H, 32'h8C, H};
        vecs[8]  = '{H, L, 32'h00, L, H, H,  L, 32'h00, H, 32'h8C, H};
        vecs[9]  = '{H, L, 32'h00, L, H, L,  L, 32'h00, H, 32'h8C, L};
        vecs[10] = '{H, L, 32'h00, H, L, L,  L, 32'h00, H, 32'h8C, L};
        vecs[11] = '{H, L, 32'h00, L, H, L,  H, 32'h94, H, 32'h90, H};
        vecs[12] = '{H, L, 32'h00, L, H, L,  L, 32'h00, H, 32'h90, H};
        vecs[13] = '{H, L, 32'h00, H, L, H,  L, 32'h00, H, 32'h90, H};
        vecs[14] = '{H, L, 32'h00, H, L, L,  H, 32'h98, H, 32'h94, H};

        rst_n = 1'b0;
        req_i = 0; branch_i = 0; branch_addr_i = 0; hwlp_jump_i = 0; hwlp_target_i = 0;
        fetch_ready_i = 0; instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = 0; instr_err_i = 0;
        modelReset();
        #12;
        checkReset("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Boot branch, streaming fetch, then back-pressure against the credit limit.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].req, vecs[i].br, vecs[i].baddr, L, 0,
                          vecs[i].rdy, vecs[i].gnt, vecs[i].rv);
            check($sformatf("tblReq%0d", i), instr_req_o, vecs[i].eReq);
            if (vecs[i].eReq) check($sformatf("tblAddr%0d", i), instr_addr_o, vecs[i].eAddr);
            check($sformatf("tblValid%0d", i), fetch_valid_o, vecs[i].eValid);
            if (vecs[i].eValid)
                check($sformatf("tblData%0d", i), fetch_rdata_o, memWord(vecs[i].eDataAddr));
            check($sformatf("tblBusy%0d", i), busy_o, vecs[i].eBusy);
        end

        // Branch with two transactions outstanding.
        applyStimulus(H, L, 0, L, 0, H, H, L);
        applyStimulus(H, L, 0, L, 0, H, H, L);
        applyStimulus(H, H, 32'h200, L, 0, H, H, L);
        applyStimulus(H, L, 0, L, 0, H, L, H);
        check("flushValid0", fetch_valid_o, 32'h0);
        applyStimulus(H, L, 0, L, 0, H, L, H);
        check("flushValid1", fetch_valid_o, 32'h0);
        expectFirstWord(32'h200, "firstAfterBranch");

        // Branch while a request is held without grant.
        drain();
        applyStimulus(L, H, 32'h40, L, 0, H, L, L);
        applyStimulus(H, L, 0, L, 0, H, L, L);
        check("holdAddr0", instr_addr_o, 32'h40);
        applyStimulus(L, H, 32'h200, L, 0, H, L, L);
        check("holdReq", instr_req_o, 32'h1);
        check("holdAddr1", instr_addr_o, 32'h40);
        applyStimulus(H, L, 0, L, 0, H, H, L);
        check("holdAddr2", instr_addr_o, 32'h40);
        applyStimulus(H, L, 0, L, 0, H, L, H);
        check("afterHoldAddr", instr_addr_o, 32'h200);
        check("heldRspDropped", fetch_valid_o, 32'h0);
        expectFirstWord(32'h200, "firstAfterHold");

        // Branch coinciding with rvalid, then a hardware-loop jump two cycles later.
        drain();
        applyStimulus(H, H, 32'h100, L, 0, H, H, L);
        applyStimulus(H, L, 0, L, 0, H, H, H);
        applyStimulus(H, H, 32'h180, L, 0, H, H, H);
        check("brRvalidDropped", fetch_valid_o, 32'h0);
        applyStimulus(H, L, 0, L, 0, H, H, L);
        applyStimulus(H, L, 0, H, 32'h302, H, H, H);
        expectFirstWord(32'h300, "firstAfterHwlp");

        // Address wrap, then reset in the middle of a transaction.
        drain();
        applyStimulus(L, H, 32'hFFFF_FFFE, L, 0, H, L, L);
        applyStimulus(H, L, 0, L, 0, H, H, L);
        check("wrapAddr0", instr_addr_o, 32'hFFFF_FFFC);
        applyStimulus(H, L, 0, L, 0, H, L, L);
        check("wrapAddr1", instr_addr_o, 32'h0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("midRst");
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(H, L, 0, L, 0, H, H, H);
            check($sformatf("postRstValid%0d", i), fetch_valid_o, 32'h0);
        end

        // Randomized traffic.
        applyStimulus(H, H, $urandom, L, 0, H, L, L);
        for (int i = 0; i < 500; i++) begin
            applyStimulus($urandom_range(0, 9) < 9, $urandom_range(0, 19) == 0, $urandom,
                          $urandom_range(0, 19) == 0, $urandom,
                          $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                          $urandom_range(0, 9) < 6);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
